// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame shape.
// The matching receiver imports this package as well.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, with a one-byte holding register so that
// the next byte can be accepted while the current one shifts out.
module uart_tx
    import uart_pkg::*;
#(
    parameter int cycles_per_bit = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_data,
    input  logic       i_req,
    output logic       o_serial,
    output logic       o_cts,
    output logic       o_idle
);

    localparam int               CNT_W    = $clog2(cycles_per_bit);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(cycles_per_bit - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t   state;
    logic [7:0]       hold;
    logic             hold_valid;
    logic [7:0]       shift;
    logic [CNT_W-1:0] cycle_cnt;
    logic [2:0]       bit_idx;
    logic             serial_q;

    logic accept;
    logic bit_done;

    assign accept   = i_req && !hold_valid;
    assign bit_done = (cycle_cnt == CNT_LAST);

    assign o_serial = serial_q;
    assign o_cts    = !hold_valid;
    assign o_idle   = (state == IDLE) && !hold_valid;

    // A load only happens with hold_valid=1, which blocks accept, so the two
    // hold_valid updates below never collide in one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hold       <= '0;
            hold_valid <= 1'b0;
            shift      <= '0;
            cycle_cnt  <= '0;
            bit_idx    <= '0;
            serial_q   <= 1'b1;
        end else begin
            if (accept) begin
                hold       <= i_data;
                hold_valid <= 1'b1;
            end

            case (state)
                IDLE: begin
                    cycle_cnt <= '0;
                    serial_q  <= 1'b1;
                    if (hold_valid) begin
                        shift      <= hold;
                        hold_valid <= 1'b0;
                        serial_q   <= 1'b0;
                        state      <= START;
                    end
                end

                START: begin
                    if (bit_done) begin
                        cycle_cnt <= '0;
                        bit_idx   <= '0;
                        serial_q  <= shift[0];
                        state     <= DATA;
                    end else begin
                        cycle_cnt <= cycle_cnt + CNT_ONE;
                    end
                end

                DATA: begin
                    if (bit_done) begin
                        cycle_cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
                            serial_q <= 1'b1;
                            state    <= STOP;
                        end else begin
                            bit_idx  <= bit_idx + 3'd1;
                            shift    <= {1'b0, shift[7:1]};
                            serial_q <= shift[1];
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + CNT_ONE;
                    end
                end

                STOP: begin
                    if (bit_done) begin
                        cycle_cnt <= '0;
                        // Back-to-back: reload straight into START with no mark gap.
                        if (hold_valid) begin
                            shift      <= hold;
                            hold_valid <= 1'b0;
                            serial_q   <= 1'b0;
                            state      <= START;
                        end else begin
                            serial_q <= 1'b1;
                            state    <= IDLE;
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + CNT_ONE;
                    end
                end

                default: begin
                    serial_q <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of single-byte frames plus hand-written
// streaming, reset-abort, idle and non-power-of-2 bit-time sequences.
module tb_uart_tx;

    localparam int CPB  = 4;
    localparam int CPB3 = 3;

    // frame holds line levels in transmit order, leftmost bit sent first
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i_data = '0;
    logic       i_req = 1'b0;
    logic       o_serial;
    logic       o_cts;
    logic       o_idle;
    logic [7:0] i_data3 = '0;
    logic       i_req3 = 1'b0;
    logic       o_serial3;
    logic       o_cts3;
    logic       o_idle3;

    int checks   = 0;
    int failures = 0;

    vec_t       vecs[8];
    logic [7:0] sdata[3];
    logic [9:0] sframes[3];
    int         acc_k[3];
    int         nacc;
    int         idx;
    bit         pend;

    always #5 clk = ~clk;

    uart_tx #(.cycles_per_bit(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_data   (i_data),
        .i_req    (i_req),
        .o_serial (o_serial),
        .o_cts    (o_cts),
        .o_idle   (o_idle)
    );

    uart_tx #(.cycles_per_bit(CPB3)) dut3 (
        .clk      (clk),
        .rst      (rst),
        .i_data   (i_data3),
        .i_req    (i_req3),
        .o_serial (o_serial3),
        .o_cts    (o_cts3),
        .o_idle   (o_idle3)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One isolated byte on the cpb=4 instance, checked every cycle of the frame
    task automatic applyStimulus(input logic [7:0] data, input logic [9:0] frame);
        @(negedge clk);
        checkOutput("cts_before_accept", o_cts, 1);
        i_req  = 1'b1;
        i_data = data;
        @(negedge clk);
        i_req  = 1'b0;
        i_data = ~data;
        checkOutput("pre_start", {o_serial, o_cts, o_idle}, 3'b100);
        for (int c = 0; c < 10 * CPB; c++) begin
            @(negedge clk);
            checkOutput("frame_bit", {o_serial, o_idle}, {frame[9 - c / CPB], 1'b0});
        end
        @(negedge clk);
        checkOutput("after_frame", {o_serial, o_cts, o_idle}, 3'b111);
    endtask

    initial begin
        vecs[0] = '{8'h48, 10'b0000100101};
        vecs[1] = '{8'h65, 10'b0101001101};
        vecs[2] = '{8'h6C, 10'b0001101101};
        vecs[3] = '{8'h00, 10'b0000000001};
        vecs[4] = '{8'hFF, 10'b0111111111};
        vecs[5] = '{8'hA5, 10'b0101001011};
        vecs[6] = '{8'h01, 10'b0100000001};
        vecs[7] = '{8'h80, 10'b0000000011};

        repeat (3) @(negedge clk);
        checkOutput("reset_state", {o_serial, o_cts, o_idle}, 3'b111);
        checkOutput("reset_state3", {o_serial3, o_cts3, o_idle3}, 3'b111);
        rst = 1'b0;

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checkOutput("quiet_line", {o_serial, o_cts, o_idle}, 3'b111);
        end

        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].data, vecs[v].frame);
        end

        // Three bytes with i_req held: accepts expected at k=0, 2 and 2+10*CPB
        sdata[0] = vecs[0].data;  sframes[0] = vecs[0].frame;
        sdata[1] = vecs[1].data;  sframes[1] = vecs[1].frame;
        sdata[2] = vecs[2].data;  sframes[2] = vecs[2].frame;
        nacc = 0;
        idx  = 0;
        pend = 1'b0;
        @(negedge clk);
        i_req  = 1'b1;
        i_data = sdata[0];
        for (int k = 0; k <= 30 * CPB + 4; k++) begin
            if (pend) begin
                pend = 1'b0;
                idx++;
                if (idx < 3) i_data = sdata[idx];
                else         i_req  = 1'b0;
            end
            if (k >= 2 && k <= 30 * CPB + 1) begin
                checkOutput("stream_bit", {o_serial, o_idle},
                            {sframes[(k - 2) / (10 * CPB)][9 - ((k - 2) % (10 * CPB)) / CPB], 1'b0});
            end else if (k > 30 * CPB + 1) begin
                checkOutput("stream_end", {o_serial, o_cts, o_idle}, 3'b111);
            end
            if (i_req && o_cts) begin
                if (nacc < 3) acc_k[nacc] = k;
                nacc++;
                pend = 1'b1;
            end
            @(negedge clk);
        end
        checkOutput("stream_accepts", nacc, 3);
        checkOutput("stream_acc0", acc_k[0], 0);
        checkOutput("stream_acc1", acc_k[1], 2);
        checkOutput("stream_acc2", acc_k[2], 2 + 10 * CPB);

        // Reset during DATA bit 3 (a 0 for 8'hF0) with a second byte held
        @(negedge clk);
        i_req  = 1'b1;
        i_data = 8'hF0;
        @(negedge clk);
        i_data = 8'h65;
        @(negedge clk);
        @(negedge clk);
        i_req = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        checkOutput("mid_frame", {o_serial, o_cts, o_idle}, 3'b000);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("reset_abort", {o_serial, o_cts, o_idle}, 3'b111);
        rst = 1'b0;
        for (int i = 0; i < 12 * CPB; i++) begin
            @(negedge clk);
            checkOutput("no_frame_after_reset", {o_serial, o_cts, o_idle}, 3'b111);
        end

        // Non-power-of-2 bit time on the cpb=3 instance
        @(negedge clk);
        i_req3  = 1'b1;
        i_data3 = vecs[5].data;
        @(negedge clk);
        i_req3  = 1'b0;
        i_data3 = 8'h00;
        checkOutput("pre_start3", {o_serial3, o_cts3, o_idle3}, 3'b100);
        for (int c = 0; c < 10 * CPB3; c++) begin
            @(negedge clk);
            checkOutput("frame_bit3", {o_serial3, o_idle3}, {vecs[5].frame[9 - c / CPB3], 1'b0});
        end
        @(negedge clk);
        checkOutput("after_frame3", {o_serial3, o_cts3, o_idle3}, 3'b111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
